// File: rtl/cmd_line_parser.sv
// Parses one ASCII command line of up to MAX_FIELDS signed/unsigned decimal fields.
// Result registered one cycle after the terminator byte; never back-pressures.
module cmd_line_parser #(
  parameter int DATA_W     = 16,
  parameter int MAX_FIELDS = 4,
  parameter int MAX_DIGITS = 5,
  parameter int SIGNED_EN  = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic [MAX_FIELDS*DATA_W-1:0]      field_data,
  output logic [$clog2(MAX_FIELDS+1)-1:0]   field_count,
  output logic                              line_valid,
  output logic [1:0]                        line_err
);

  localparam int CNT_W = $clog2(MAX_FIELDS+1);
  localparam int DIG_W = $clog2(MAX_DIGITS+2);
  localparam int ACC_W = DATA_W + 4;

  localparam logic [ACC_W-1:0] LIM_U = {4'b0000, {DATA_W{1'b1}}};
  localparam logic [ACC_W-1:0] LIM_P = {5'b00000, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] LIM_N = {4'b0000, 1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [1:0] E_OK  = 2'd0;
  localparam logic [1:0] E_SYN = 2'd1;
  localparam logic [1:0] E_OVF = 2'd2;
  localparam logic [1:0] E_MAX = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SIGN, S_NUM, S_ERR} state_e;

  state_e                         state_q, state_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [DIG_W-1:0]               dig_q, dig_d;
  logic                           neg_q, neg_d;
  logic [MAX_FIELDS*DATA_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [1:0]                     err_q, err_d;
  logic [MAX_FIELDS*DATA_W-1:0]   field_data_q, field_data_d;
  logic [CNT_W-1:0]               field_count_q, field_count_d;
  logic                           line_valid_q, line_valid_d;
  logic [1:0]                     line_err_q, line_err_d;

  logic             is_dig, is_sep, is_term, is_minus, minus_ok;
  logic [ACC_W-1:0] acc_nxt, lim;
  logic [DIG_W-1:0] dig_nxt;
  logic             ovf, full, commit, emit;
  logic [DATA_W-1:0] mag, val;

  assign is_dig   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_sep   = (rx_data == 8'h20) || (rx_data == 8'h2C);
  assign is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_minus = (rx_data == 8'h2D);
  assign minus_ok = is_minus && (SIGNED_EN != 0);

  // acc never exceeds the limit before a multiply, so ACC_W bits cannot wrap
  assign acc_nxt = (acc_q << 3) + (acc_q << 1) + {{DATA_W{1'b0}}, rx_data[3:0]};
  assign dig_nxt = dig_q + 1'b1;

  always_comb begin
    if (SIGNED_EN == 0) lim = LIM_U;
    else if (neg_q)     lim = LIM_N;
    else                lim = LIM_P;
  end

  assign ovf    = (dig_nxt > DIG_W'(MAX_DIGITS)) || (acc_nxt > lim);
  assign full   = (cnt_q == CNT_W'(MAX_FIELDS));
  assign mag    = acc_q[DATA_W-1:0];
  assign val    = neg_q ? (~mag + 1'b1) : mag;
  assign commit = rx_valid && (state_q == S_NUM) && (is_sep || is_term);
  assign emit   = rx_valid && is_term && ((state_q != S_IDLE) || (cnt_q != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      dig_q         <= '0;
      neg_q         <= 1'b0;
      buf_q         <= '0;
      cnt_q         <= '0;
      err_q         <= E_OK;
      field_data_q  <= '0;
      field_count_q <= '0;
      line_valid_q  <= 1'b0;
      line_err_q    <= E_OK;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      dig_q         <= dig_d;
      neg_q         <= neg_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      field_data_q  <= field_data_d;
      field_count_q <= field_count_d;
      line_valid_q  <= line_valid_d;
      line_err_q    <= line_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (is_dig)                state_d = ovf ? S_ERR : S_NUM;
          else if (minus_ok)         state_d = S_SIGN;
          else if (is_sep || is_term) state_d = S_IDLE;
          else                       state_d = S_ERR;
        end
        S_SIGN: begin
          if (is_dig)       state_d = ovf ? S_ERR : S_NUM;
          else if (is_term) state_d = S_IDLE;
          else              state_d = S_ERR;
        end
        S_NUM: begin
          if (is_dig)       state_d = ovf ? S_ERR : S_NUM;
          else if (is_sep)  state_d = full ? S_ERR : S_IDLE;
          else if (is_term) state_d = S_IDLE;
          else              state_d = S_ERR;
        end
        default: begin
          if (is_term) state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    acc_d         = acc_q;
    dig_d         = dig_q;
    neg_d         = neg_q;
    buf_d         = buf_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    field_data_d  = field_data_q;
    field_count_d = field_count_q;
    line_err_d    = line_err_q;
    line_valid_d  = 1'b0;

    // err_q is always clear outside S_ERR, so the first error of a line sticks
    if (rx_valid && (state_q != S_ERR)) begin
      if (is_dig) begin
        if (ovf) begin
          err_d = E_OVF;
        end else begin
          acc_d = acc_nxt;
          dig_d = dig_nxt;
        end
      end else if (state_q == S_IDLE) begin
        if (minus_ok)                   neg_d = 1'b1;
        else if (!(is_sep || is_term))  err_d = E_SYN;
      end else if (state_q == S_SIGN) begin
        err_d = E_SYN;
      end else if (!commit) begin
        err_d = E_SYN;
      end
    end

    if (commit) begin
      if (full) begin
        err_d = E_MAX;
      end else begin
        buf_d[cnt_q*DATA_W +: DATA_W] = val;
        cnt_d = cnt_q + 1'b1;
      end
      acc_d = '0;
      dig_d = '0;
      neg_d = 1'b0;
    end

    if (emit) begin
      line_valid_d = 1'b1;
      line_err_d   = err_d;
      if (err_d == E_OK) begin
        field_data_d  = buf_d;
        field_count_d = cnt_d;
      end else begin
        field_data_d  = '0;
        field_count_d = '0;
      end
      acc_d = '0;
      dig_d = '0;
      neg_d = 1'b0;
      buf_d = '0;
      cnt_d = '0;
      err_d = E_OK;
    end
  end

  always_comb begin
    field_data  = field_data_q;
    field_count = field_count_q;
    line_valid  = line_valid_q;
    line_err    = line_err_q;
  end

endmodule

// File: tb/tb_cmd_line_parser.sv
// Directed bench for cmd_line_parser with DATA_W=16, MAX_FIELDS=4, MAX_DIGITS=5, SIGNED_EN=1.
module tb_cmd_line_parser;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [63:0] field_data;
  logic [2:0]  field_count;
  logic        line_valid;
  logic [1:0]  line_err;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  cmd_line_parser #(
    .DATA_W(16), .MAX_FIELDS(4), .MAX_DIGITS(5), .SIGNED_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .field_data(field_data), .field_count(field_count),
    .line_valid(line_valid), .line_err(line_err)
  );

  always #5 clk = ~clk;

  // Sampled at posedge so it sees the pre-edge value of the registered strobe
  always @(posedge clk) if (line_valid === 1'b1) pulses = pulses + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Sends a line and checks the strobe state one cycle after the terminator edge
  task automatic send_line(input string tag, input string s, input logic [7:0] term,
                           input logic exp_pulse);
    send_str(s);
    send_byte(term);
    check({tag, ".strobe"}, {63'd0, line_valid}, {63'd0, exp_pulse});
  endtask

  task automatic check_result(input string tag, input logic [63:0] data,
                              input logic [2:0] cnt, input logic [1:0] err);
    check({tag, ".data"}, field_data, data);
    check({tag, ".count"}, {61'd0, field_count}, {61'd0, cnt});
    check({tag, ".err"}, {62'd0, line_err}, {62'd0, err});
  endtask

  task automatic settle_pulses(input string tag, input int exp);
    @(negedge clk);
    @(negedge clk);
    check({tag, ".pulses"}, 64'(pulses - p0), 64'(exp));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_result("reset", 64'd0, 3'd0, 2'd0);
    check("reset.valid", {63'd0, line_valid}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    p0 = pulses;
    send_line("basic", "12 345,7", CR, 1'b1);
    check_result("basic", 64'h0000_0007_0159_000C, 3'd3, 2'd0);
    settle_pulses("basic", 1);

    send_line("minmax", "-32768  32767", CR, 1'b1);
    check_result("minmax", 64'h0000_0000_7FFF_8000, 3'd2, 2'd0);

    send_line("ovf_mag", "32768", CR, 1'b1);
    check_result("ovf_mag", 64'd0, 3'd0, 2'd2);

    send_line("ovf_dig", "000001", CR, 1'b1);
    check_result("ovf_dig", 64'd0, 3'd0, 2'd2);

    send_line("toomany", "1 2 3 4 5", CR, 1'b1);
    check_result("toomany", 64'd0, 3'd0, 2'd3);

    send_line("four", "4,3,2,1", LF, 1'b1);
    check_result("four", 64'h0001_0002_0003_0004, 3'd4, 2'd0);

    send_line("illegal", "12a3", CR, 1'b1);
    check_result("illegal", 64'd0, 3'd0, 2'd1);

    send_line("lone_minus", "- 5", CR, 1'b1);
    check_result("lone_minus", 64'd0, 3'd0, 2'd1);

    send_line("recover", "9", CR, 1'b1);
    check_result("recover", 64'd9, 3'd1, 2'd0);

    @(negedge clk);
    p0 = pulses;
    send_line("crlf", "", CR, 1'b0);
    send_byte(LF);
    send_line("spaces", "   ", CR, 1'b0);
    send_line("lf", "", LF, 1'b0);
    settle_pulses("empty", 0);
    check_result("empty_hold", 64'd9, 3'd1, 2'd0);

    p0 = pulses;
    send_line("seven", "7", CR, 1'b1);
    send_byte(LF);
    settle_pulses("seven", 1);
    check_result("seven", 64'd7, 3'd1, 2'd0);

    send_str("45");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_result("midreset", 64'd0, 3'd0, 2'd0);
    send_line("after_rst", "6", CR, 1'b1);
    check_result("after_rst", 64'd6, 3'd1, 2'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
